led_frame_loader: RTL and testbench

- Upstream stage of the LED strip driver. Receives one full strip frame (NUM_LEDS x BITS_PER_LED bits) from the MCU over a write-only SPI link (mode 0, MSB first).
- Presents the frame as a stable, double-buffered parallel vector to the strip driver's led_string input.
- The output changes only on a complete, correctly sized frame, so the driver never streams a half-written frame.

---
 rtl/led_frame_loader_if.sv | 29 ++
 rtl/led_frame_loader.sv | 149 ++++++++++++++
 tb/tb_led_frame_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_loader_if.sv
// led_frame_loader_if: SPI link from the MCU plus the committed-frame outputs
// presented to the strip driver.
//   sck, sdi, cs_n : SPI mode 0 lines driven by the MCU (async to clk)
//   led_string     : committed frame, LED0 in the top BITS_PER_LED bits
//   frame_valid    : one-cycle pulse when led_string updates
//   frame_err      : one-cycle pulse when a frame is discarded
//   busy           : loader is receiving or checking a frame
// WIDTH must equal NUM_LEDS*BITS_PER_LED of the attached loader.
interface led_frame_loader_if #(
  parameter int unsigned WIDTH = 3456
);
  logic             sck;
  logic             sdi;
  logic             cs_n;
  logic [WIDTH-1:0] led_string;
  logic             frame_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output sck, sdi, cs_n,
    input  led_string, frame_valid, frame_err, busy
  );

  modport slave (
    input  sck, sdi, cs_n,
    output led_string, frame_valid, frame_err, busy
  );
endinterface

// File: rtl/led_frame_loader.sv
// led_frame_loader: receives one strip frame over write-only SPI (mode 0,
// MSB first) and presents it as a double-buffered parallel vector. The
// output changes only when exactly NUM_LEDS*BITS_PER_LED bits arrived
// between a cs_n fall and rise.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : led_frame_loader_if.slave (sck/sdi/cs_n in; led_string,
//         frame_valid, frame_err, busy out)
module led_frame_loader #(
  parameter int unsigned NUM_LEDS     = 144,
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  led_frame_loader_if.slave bus
);

  localparam int unsigned W  = NUM_LEDS * BITS_PER_LED;
  localparam int unsigned CW = $clog2(W + 2);
  localparam logic [CW-1:0] FULL = CW'(W);
  // One past a full frame marks overflow; the counter parks here.
  localparam logic [CW-1:0] SAT  = CW'(W + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECV,
    CHECK
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_sr, sdi_sr, cs_sr;
  logic                   sck_s, sdi_s, cs_s;
  logic                   sck_q, cs_q;
  logic                   sck_rise, cs_rise, cs_fall;

  logic [W-1:0]  work;
  logic [CW-1:0] cnt;
  logic          pend, pend_nx;

  logic clr_cnt, take_bit, commit, discard;

  // Synchronisers reset to 0 so a cs_n already low at reset release is not
  // mistaken for idle; WAIT_IDLE then holds until cs_n is really seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sr <= '0;
      sdi_sr <= '0;
      cs_sr  <= '0;
      sck_q  <= 1'b0;
      cs_q   <= 1'b0;
    end else begin
      sck_sr[0] <= bus.sck;
      sdi_sr[0] <= bus.sdi;
      cs_sr[0]  <= bus.cs_n;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sck_sr[i] <= sck_sr[i-1];
        sdi_sr[i] <= sdi_sr[i-1];
        cs_sr[i]  <= cs_sr[i-1];
      end
      sck_q <= sck_s;
      cs_q  <= cs_s;
    end
  end

  assign sck_s    = sck_sr[SYNC_STAGES-1];
  assign sdi_s    = sdi_sr[SYNC_STAGES-1];
  assign cs_s     = cs_sr[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign cs_fall  = ~cs_s & cs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_IDLE;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    clr_cnt  = 1'b0;
    take_bit = 1'b0;
    commit   = 1'b0;
    discard  = 1'b0;
    unique case (state)
      WAIT_IDLE: begin
        pend_nx = 1'b0;
        if (cs_s) state_nx = IDLE;
      end
      IDLE: begin
        if (cs_fall || pend) begin
          state_nx = RECV;
          clr_cnt  = 1'b0 | 1'b1;
          pend_nx  = 1'b0;
        end
      end
      RECV: begin
        // cs_rise implies cs_s high, so a coincident sck rise is dropped.
        if (cs_rise) begin
          state_nx = CHECK;
        end else if (sck_rise && !cs_s && cnt != SAT) begin
          take_bit = 1'b1;
        end
      end
      CHECK: begin
        state_nx = IDLE;
        if (cnt == FULL) commit  = 1'b1;
        else             discard = 1'b1;
        // A new frame starting during CHECK is remembered for IDLE.
        if (cs_fall) pend_nx = 1'b1;
      end
      default: state_nx = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (take_bit) begin
      cnt <= cnt + 1'b1;
      if (cnt < FULL) work <= {work[W-2:0], sdi_s};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.led_string  <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
    end else begin
      bus.frame_valid <= commit;
      bus.frame_err   <= discard;
      if (commit) bus.led_string <= work;
    end
  end

  assign bus.busy = (state == RECV) || (state == CHECK);

endmodule

// File: tb/tb_led_frame_loader.sv
// tb_led_frame_loader: directed test of led_frame_loader on a reduced
// 6-LED strip so each frame stays short; frames, pulse counts, latency and
// busy duration are compared against hand-built expectations.
module tb_led_frame_loader;

  localparam int unsigned NL  = 6;
  localparam int unsigned BPL = 24;
  localparam int unsigned SS  = 2;
  localparam int unsigned W   = NL * BPL;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_frame_loader_if #(.WIDTH(W)) bus ();

  led_frame_loader #(
    .NUM_LEDS    (NL),
    .BITS_PER_LED(BPL),
    .SYNC_STAGES (SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int nv = 0, ne = 0, nboth = 0, nbusy = 0;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) nv++;
    if (bus.frame_err === 1'b1) ne++;
    if (bus.frame_valid === 1'b1 && bus.frame_err === 1'b1) nboth++;
    if (bus.busy === 1'b1) nbusy++;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic spi_bit(input logic b);
    bus.sdi = b;
    #40 bus.sck = 1'b1;
    #40 bus.sck = 1'b0;
  endtask

  // Sends the low n bits of d, bit n-1 first.
  task automatic spi_bits(input logic [W+7:0] d, input int unsigned n);
    for (int unsigned i = n; i > 0; i--) spi_bit(d[i-1]);
  endtask

  task automatic begin_frame();
    bus.cs_n = 1'b0;
    #40;
  endtask

  // Raises cs_n and returns the number of clk edges until a pulse (0 = none).
  task automatic end_frame(output int unsigned lat);
    #40 bus.cs_n = 1'b1;
    lat = 0;
    for (int unsigned k = 1; k <= 12 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_valid === 1'b1 || bus.frame_err === 1'b1) lat = k;
    end
    repeat (6) @(posedge clk);
    #7;
  endtask

  task automatic send_frame(input logic [W+7:0] d, input int unsigned n, output int unsigned lat);
    begin_frame();
    spi_bits(d, n);
    end_frame(lat);
  endtask

  logic [W-1:0]   f1, aa, p55, p123, pabc, p0f;
  logic [W+7:0]   d;
  int unsigned    lat;
  int             v0, e0, b0;

  initial begin
    f1   = {24'hFF0000, {(NL-2){24'h00FF00}}, 24'h0000FF};
    aa   = {(W/8){8'hAA}};
    p55  = {(W/8){8'h55}};
    p123 = {NL{24'h123456}};
    pabc = {NL{24'hABCDEF}};
    p0f  = {NL{24'h0F0F0F}};

    bus.sck = 1'b0;
    bus.sdi = 1'b0;
    bus.cs_n = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", bus.led_string, '0);
    check("rst_valid", W'(bus.frame_valid), '0);
    check("rst_err", W'(bus.frame_err), '0);
    check("rst_busy", W'(bus.busy), '0);
    @(posedge clk);
    #7;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #7;

    // Full frame with distinct first, middle and last LEDs.
    v0 = nv; e0 = ne;
    d = '0; d[W-1:0] = f1;
    send_frame(d, W, lat);
    check("full_latency", W'(lat), W'(SS + 2));
    check("full_valid_cnt", W'(nv - v0), W'(1));
    check("full_err_cnt", W'(ne - e0), '0);
    check("full_led0", W'(bus.led_string[W-1 -: 24]), W'(24'hFF0000));
    check("full_led1", W'(bus.led_string[W-25 -: 24]), W'(24'h00FF00));
    check("full_led_last", W'(bus.led_string[23:0]), W'(24'h0000FF));
    check("full_led_all", bus.led_string, f1);

    // One bit short.
    v0 = nv; e0 = ne;
    d = '0; d[W-2:0] = '1;
    send_frame(d, W - 1, lat);
    check("short_err_cnt", W'(ne - e0), W'(1));
    check("short_valid_cnt", W'(nv - v0), '0);
    check("short_led_held", bus.led_string, f1);

    // Four bits long.
    v0 = nv; e0 = ne;
    d = '0; d[W+3:0] = {aa, 4'hB};
    send_frame(d, W + 4, lat);
    check("long_err_cnt", W'(ne - e0), W'(1));
    check("long_valid_cnt", W'(nv - v0), '0);
    check("long_led_held", bus.led_string, f1);

    v0 = nv; e0 = ne;
    d = '0; d[W-1:0] = p55;
    send_frame(d, W, lat);
    check("after_long_valid_cnt", W'(nv - v0), W'(1));
    check("after_long_err_cnt", W'(ne - e0), '0);
    check("after_long_led", bus.led_string, p55);

    // Back-to-back frames with cs_n high for 3 clk between them.
    v0 = nv; e0 = ne;
    d = '0; d[W-1:0] = p123;
    begin_frame();
    spi_bits(d, W);
    #40 bus.cs_n = 1'b1;
    #30 bus.cs_n = 1'b0;
    #40;
    d = '0; d[W-1:0] = pabc;
    spi_bits(d, W);
    end_frame(lat);
    check("b2b_valid_cnt", W'(nv - v0), W'(2));
    check("b2b_err_cnt", W'(ne - e0), '0);
    check("b2b_led", bus.led_string, pabc);

    // Reset in the middle of a frame; the tail must be ignored.
    v0 = nv; e0 = ne;
    d = '0; d[W-1:0] = p123;
    begin_frame();
    spi_bits(d, 40);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #7;
    rst = 1'b0;
    spi_bits(d, W - 40);
    check("rst_mid_busy", W'(bus.busy), '0);
    check("rst_mid_led", bus.led_string, '0);
    #40 bus.cs_n = 1'b1;
    repeat (10) @(posedge clk);
    #7;
    check("rst_mid_valid_cnt", W'(nv - v0), '0);
    check("rst_mid_err_cnt", W'(ne - e0), '0);
    check("rst_mid_led_after", bus.led_string, '0);

    v0 = nv; e0 = ne;
    d = '0; d[W-1:0] = p0f;
    send_frame(d, W, lat);
    check("post_rst_latency", W'(lat), W'(SS + 2));
    check("post_rst_valid_cnt", W'(nv - v0), W'(1));
    check("post_rst_led", bus.led_string, p0f);

    // Empty frame: cs_n low for 12 clk with no sck.
    v0 = nv; e0 = ne; b0 = nbusy;
    begin_frame();
    check("empty_busy_mid", W'(bus.busy), W'(1));
    #40;
    end_frame(lat);
    check("empty_err_cnt", W'(ne - e0), W'(1));
    check("empty_valid_cnt", W'(nv - v0), '0);
    check("empty_busy_cycles", W'(nbusy - b0), W'(13));
    check("empty_led_held", bus.led_string, p0f);
    check("empty_busy_end", W'(bus.busy), '0);

    check("valid_err_overlap", W'(nboth), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
